// File: rtl/lut_pkg.sv
// Shared types and derived sizes for the LUT sweep unit.
package lut_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;

  function automatic int depth(input int n_in);
    return 1 << n_in;
  endfunction

  // One extra bit so the sweep terminal count (DEPTH) never aliases index 0.
  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  localparam int N_IN_DEF  = 4;
  localparam int DEPTH_DEF = 1 << N_IN_DEF;
  localparam int CNT_W_DEF = N_IN_DEF + 1;
endpackage

// File: rtl/lut_bank.sv
// One channel's truth table: serial-load write port, single combinational read port.
module lut_bank
  import lut_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] i_waddr,
  input  logic            i_wbit,
  input  logic            i_we,
  input  logic [N_IN-1:0] i_raddr,
  output logic            o_rbit
);
  localparam int DEPTH = depth(N_IN);

  logic [DEPTH-1:0] r_tbl;

  always_ff @(posedge clk) begin
    if (rst)       r_tbl <= '0;
    else if (i_we) r_tbl[i_waddr] <= i_wbit;
  end

  assign o_rbit = r_tbl[i_raddr];
endmodule

// File: rtl/lut_sweep_unit.sv
// Multi-channel loadable truth-table unit with live eval and full-index sweep.
// Optional sweep pause port enabled by LUT_SWEEP_STALL_EN.
module lut_sweep_unit
  import lut_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int N_CH = 2,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  inVec,
  input  logic             inLoad,
  input  logic [SEL_W-1:0] inSel,
  input  logic             inBit,
  input  logic             inValid,
  input  logic             inSweep,
`ifdef LUT_SWEEP_STALL_EN
  input  logic             inStall,
`endif
  output logic [N_CH-1:0]  Y,
  output logic [N_IN-1:0]  outIdx,
  output logic             outValid,
  output logic             busy,
  output logic             done
);
  localparam int DEPTH = depth(N_IN);
  localparam int CNT_W = cnt_w(N_IN);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel;

  logic             w_load_go, w_sweep_go, w_stall;
  logic [N_IN-1:0]  w_raddr;
  logic [N_CH-1:0]  w_rd;

  assign w_load_go  = (r_state == IDLE) && inLoad && (int'(inSel) < N_CH);
  assign w_sweep_go = (r_state == IDLE) && !w_load_go && inSweep;

`ifdef LUT_SWEEP_STALL_EN
  assign w_stall = inStall && (r_state == SWEEP);
`else
  assign w_stall = 1'b0;
`endif

  // The sweep's first beat is emitted on the accepting edge, so read index 0 then.
  always_comb begin
    w_raddr = r_cnt[N_IN-1:0];
    if (r_state == IDLE) w_raddr = w_sweep_go ? '0 : inVec;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_bank
    lut_bank #(.N_IN(N_IN)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .i_waddr (r_cnt[N_IN-1:0]),
      .i_wbit  (inBit),
      .i_we    ((r_state == LOAD) && inValid && (r_sel == SEL_W'(g))),
      .i_raddr (w_raddr),
      .o_rbit  (w_rd[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sel    <= '0;
      Y        <= '0;
      outIdx   <= '0;
      outValid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          Y        <= w_rd;
          outValid <= 1'b0;
          if (w_load_go) begin
            r_state <= LOAD;
            r_sel   <= inSel;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end else if (w_sweep_go) begin
            r_state  <= SWEEP;
            r_cnt    <= CNT_W'(1);
            outIdx   <= '0;
            outValid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (inValid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(DEPTH - 1)) begin
              r_state <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        SWEEP: begin
          if (w_stall) begin
            outValid <= 1'b0;
          end else if (r_cnt == CNT_W'(DEPTH)) begin
            r_state  <= IDLE;
            outValid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            Y        <= w_rd;
            outIdx   <= r_cnt[N_IN-1:0];
            outValid <= 1'b1;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
